// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the pc register, fetches over a req/gnt/rvalid
// handshake, and queues {pc, instr} for decode. Optional macro: IF_ALIGN_CHECK_EN.
module if_fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  newpc,
  output logic               pc_write,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic               if_misalign
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DROP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_e             state_q;
  logic [ADDR_W-1:0]  req_pc_q;
  logic [ADDR_W-1:0]  newpc_q;
  logic               pc_write_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             mem_q [DEPTH];
  entry_t             head;
  logic               grant, push_d, pop_d, fetch_block;

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign if_misalign = misalign_q;
  assign fetch_block = misalign_q;
`else
  assign fetch_block = 1'b0;
`endif

  // Hold off while a pc write is pending: the pc input is stale until it lands.
  assign imem_req  = (state_q == S_FETCH) && !pc_write_q && (count_q < DEPTH_C) && !fetch_block;
  assign imem_addr = imem_req ? pc : '0;
  assign grant     = imem_req && imem_gnt;
  assign push_d    = (state_q == S_WAIT) && imem_rvalid && !branch_taken;
  assign pop_d     = if_valid && id_ready;
  assign count_d   = count_q + CNT_W'(push_d) - CNT_W'(pop_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_pc_q   <= '0;
      newpc_q    <= '0;
      pc_write_q <= 1'b0;
    end else begin
      // NOTE: non-blocking default makes pc_write a one-cycle pulse; later
      // assignments in this block override it without ordering hazards.
      pc_write_q <= 1'b0;
      if (grant) begin
        req_pc_q <= pc;
      end
      if (branch_taken) begin
        pc_write_q <= 1'b1;
        newpc_q    <= branch_target;
      end else if (grant) begin
        pc_write_q <= 1'b1;
        newpc_q    <= pc + ADDR_W'(4);
      end

      case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        S_FETCH: if (grant) state_q <= branch_taken ? S_DROP : S_WAIT;
        S_WAIT: begin
          if (imem_rvalid)       state_q <= S_FETCH;
          else if (branch_taken) state_q <= S_DROP;
        end
        S_DROP:  if (imem_rvalid) state_q <= S_FETCH;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (branch_taken) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_d)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_rdata};
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? head.pc    : '0;
  assign if_instr = if_valid ? head.instr : '0;
  assign newpc    = newpc_q;
  assign pc_write = pc_write_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural fetch model plus directed scenarios,
// with an environment pc register and a fixed-latency instruction memory.
module tb_if_fetch_unit;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 2;
`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  newpc;
  logic               pc_write;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               branch_taken = 1'b0;
  logic [ADDR_W-1:0]  branch_target = '0;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
  logic               if_misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .newpc(newpc), .pc_write(pc_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
`ifdef IF_ALIGN_CHECK_EN
    , .if_misalign(if_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 64'h1000) return 32'hD503201F;
    return a[31:0] ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment: pc register and a fixed-latency memory responder.
  logic [ADDR_W-1:0] reset_pc = 64'h1000;
  logic              gnt_en = 1'b0;
  int                rsp_lat = 1;
  int                rsp_cnt = 0;
  logic [ADDR_W-1:0] rsp_addr = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset)        pc <= reset_pc;
    else if (pc_write) pc <= newpc;
  end

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      rsp_cnt  <= rsp_lat;
      rsp_addr <= imem_addr;
    end else if (rsp_cnt != 0) begin
      rsp_cnt <= rsp_cnt - 1;
    end
  end

  assign imem_gnt    = gnt_en;
  assign imem_rvalid = (rsp_cnt == 1);
  assign imem_rdata  = imem_rvalid ? mem_word(rsp_addr) : '0;

  // Behavioural model: one outstanding fetch that a redirect can poison,
  // an expected instruction queue, and the expected pc-register writes.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  ent_t              mq[$];
  bit                m_pend, m_ok, m_idle, m_pcw, m_mis;
  logic [ADDR_W-1:0] m_newpc, m_paddr;
  bit                exp_req;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pend = 1'b0; m_ok = 1'b0; m_idle = 1'b1; m_pcw = 1'b0; m_mis = 1'b0;
      m_newpc = '0; m_paddr = '0;
    end else begin
      automatic bit grant = imem_req && imem_gnt;
      if (mq.size() > 0 && id_ready) void'(mq.pop_front());
      m_pcw  = 1'b0;
      m_idle = 1'b0;
      if (branch_taken) begin
        mq.delete();
        if (imem_rvalid) m_pend = 1'b0;
        else             m_ok   = 1'b0;
        if (grant) begin m_pend = 1'b1; m_ok = 1'b0; end
        m_pcw   = 1'b1;
        m_newpc = branch_target;
        if (ALIGN_EN && branch_target[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
        if (imem_rvalid && m_pend) begin
          if (m_ok) mq.push_back(ent_t'{m_paddr, mem_word(m_paddr)});
          m_pend = 1'b0;
        end
        if (grant) begin
          m_pend = 1'b1; m_ok = 1'b1; m_paddr = pc;
          m_pcw = 1'b1;  m_newpc = pc + 64'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      exp_req = !m_idle && !m_pend && !m_pcw && (mq.size() < DEPTH) && !m_mis;
      check("m_imem_req", imem_req, exp_req);
      if (imem_req) check("m_imem_addr", imem_addr, pc);
      check("m_pc_write", pc_write, m_pcw);
      check("m_newpc", newpc, m_newpc);
      check("m_if_valid", if_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("m_if_pc", if_pc, mq[0].pc);
        check("m_if_instr", if_instr, mq[0].instr);
      end
`ifdef IF_ALIGN_CHECK_EN
      check("m_misalign", if_misalign, m_mis);
`endif
    end
  end

  // Directed helpers.
  function automatic bit cond(input int sel);
    case (sel)
      0:       return imem_req && imem_gnt;
      1:       return pc_write;
      2:       return imem_req;
      default: return if_valid;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cond(sel)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL %s: timed out waiting", name);
    end
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] rpc, input int lat, input logic rdy);
    @(posedge clk); #1;
    gnt_en = 1'b0; branch_taken = 1'b0; reset_pc = rpc;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rsp_lat = lat; id_ready = rdy; gnt_en = 1'b1;
    reset = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_imem_req"},  imem_req,  0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_pc_write"},  pc_write,  0);
    check({tag, "_newpc"},     newpc,     0);
    check({tag, "_if_valid"},  if_valid,  0);
    check({tag, "_if_instr"},  if_instr,  0);
    check({tag, "_if_pc"},     if_pc,     0);
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] tgt);
    branch_target = tgt; branch_taken = 1'b1;
    @(posedge clk); #1;
    branch_taken = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] acc0, acc1, req_a;
    int  got;
    bit  seen;

    repeat (3) @(negedge clk);
    check_zero("rst");

    // Basic fetch: pc 0x1000, immediate grant, response one cycle later.
    do_reset(64'h1000, 1, 1'b1);
    wait_cond(1, "t1_pcw");
    check("t1_newpc", newpc, 64'h1004);
    wait_cond(3, "t1_valid");
    check("t1_if_pc", if_pc, 64'h1000);
    check("t1_if_instr", if_instr, 32'hD503201F);

    // Backpressure: queue fills to DEPTH, fetching stops, drains in order.
    do_reset(64'h1000, 1, 1'b0);
    repeat (12) @(negedge clk);
    check("t2_req_stall", imem_req, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_pc", if_pc, 64'h1000);
      check("t2_hold_instr", if_instr, 32'hD503201F);
    end
    @(posedge clk); #1;
    id_ready = 1'b1;
    got = 0; seen = 1'b0; acc0 = '0; acc1 = '0; req_a = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_valid && id_ready && got < 2) begin
        if (got == 0) acc0 = if_pc; else acc1 = if_pc;
        got++;
      end
      if (imem_req && !seen) begin seen = 1'b1; req_a = imem_addr; end
      if (got == 2 && seen) break;
    end
    check("t2_drain0", acc0, 64'h1000);
    check("t2_drain1", acc1, 64'h1004);
    check("t2_resume", req_a, 64'h1008);

    // Redirect in WAIT; the stale response arrives two cycles later.
    do_reset(64'h1000, 3, 1'b1);
    wait_cond(0, "t3_gnt");
    @(posedge clk); #1;
    redirect(64'h2000);
    @(negedge clk);
    check("t3_pcw", pc_write, 1);
    check("t3_newpc", newpc, 64'h2000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req) begin
        check("t3_addr", imem_addr, 64'h2000);
        seen = 1'b1;
        break;
      end
      check("t3_no_valid", if_valid, 0);
    end
    check("t3_req_seen", seen, 1);

    // Redirect in the same cycle as rvalid, with a queued entry to flush.
    do_reset(64'h1000, 2, 1'b0);
    wait_cond(0, "t4_gnt0");
    wait_cond(0, "t4_gnt1");
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect(64'h3000);
    @(negedge clk);
    check("t4_pcw", pc_write, 1);
    check("t4_newpc", newpc, 64'h3000);
    check("t4_flush", if_valid, 0);
    wait_cond(2, "t4_req");
    check("t4_addr", imem_addr, 64'h3000);

    // pc + 4 wraps to zero.
    do_reset(64'hFFFF_FFFF_FFFF_FFFC, 1, 1'b1);
    wait_cond(1, "t5_pcw");
    check("t5_wrap", newpc, 64'h0);

    // Reset mid-WAIT with a queued entry; the late response must be ignored.
    do_reset(64'h1000, 4, 1'b0);
    wait_cond(0, "t6_gnt0");
    wait_cond(0, "t6_gnt1");
    @(posedge clk); #1;
    gnt_en = 1'b0;
    reset = 1'b0;
    #1;
    check_zero("t6");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_valid", if_valid, 0);
    end

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned redirect is sticky and stops fetching.
    do_reset(64'h1000, 1, 1'b1);
    wait_cond(0, "t7_gnt");
    @(posedge clk); #1;
    redirect(64'h2002);
    @(negedge clk);
    check("t7_misalign", if_misalign, 1);
    check("t7_newpc", newpc, 64'h2002);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t7_no_req", imem_req, 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the pc register.
- It generates `newpc` and `pc_write`, which drive the pc register's newpc/write inputs, and reads back the current pc.
- It issues instruction-memory requests with a request/grant/response handshake and buffers the returned instructions in a small queue.
- It presents `{pc, instr}` to the decode stage with valid/ready flow control and handles branch redirects and flushes.

Parameters:
- ADDR_W, 64, width of pc and instruction address.
- INSTR_W, 32, instruction width.
- DEPTH, 2, instruction queue entries (power of 2, ≥2).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pc  input  ADDR_W  current value from the pc register.
- newpc  output  ADDR_W  next pc value to the pc register.
- pc_write  output  1  write strobe to the pc register.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_W  fetch address.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid.
- imem_rdata  input  INSTR_W  response instruction.
- branch_taken  input  1  one-cycle redirect pulse from execute.
- branch_target  input  ADDR_W  redirect address.
- if_valid  output  1  decode output valid.
- if_instr  output  INSTR_W  decode instruction.
- if_pc  output  ADDR_W  pc of if_instr.
- id_ready  input  1  decode accepts the output.

Behaviour:
- Reset (reset=0, async): state=IDLE; queue empty; req_pc=0. All outputs are 0: `imem_req`, `imem_addr`, `pc_write`, `newpc`, `if_valid`, `if_instr`, `if_pc`.
- Outputs `newpc` and `pc_write` are registered.
- `imem_req` and `imem_addr` are combinational from state and `pc`.

States:
- IDLE: first cycle after reset release; goes to FETCH.
- FETCH: issue a request only when count + 0 < DEPTH (one outstanding max, credit reserved). When issuing, `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_gnt`.
  - On `imem_gnt`: req_pc←`pc`; next cycle `pc_write`=1 and `newpc`=`pc`+4 (one-cycle pulse); state←WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`: push `{req_pc, imem_rdata}` into the queue; state←FETCH.
  - The pc register updates before the next FETCH because the response arrives ≥1 cycle after grant.
- DROP: an outstanding response must be discarded. On `imem_rvalid`: data discarded, nothing pushed; state←FETCH.

Queue:
- FIFO, head drives `if_valid`, `if_instr`, `if_pc`.
- Pop when `if_valid` && `id_ready`.
- Push and pop in the same cycle are both honoured.
- Latency: with the queue empty, `if_valid`=1 the cycle after `imem_rvalid`.
- The credit rule guarantees no push while full.
- While `id_ready`=0, the head and all outputs stay stable.

Redirect (`branch_taken`=1) has highest priority:
- Queue flushed: `if_valid`=0 next cycle.
- Next cycle `pc_write`=1 and `newpc`=`branch_target`. The `pc+4` update of that cycle is suppressed.
- State transitions on redirect:
  - From FETCH, not granted: `imem_req` drops next cycle; state←FETCH.
  - From FETCH, granted the same cycle: state←DROP.
  - From WAIT, no `rvalid` the same cycle: state←DROP.
  - From WAIT, `rvalid` the same cycle: response discarded; state←FETCH.
  - From DROP: state stays DROP (or goes to FETCH if `rvalid` arrives the same cycle).
- A second redirect while in DROP overwrites `newpc` again; the newest target wins.

Further rules:
- Arithmetic: `pc`+4 is modulo 2^ADDR_W (wraps from all-ones−3 to 0).
- Reset mid-transaction: everything clears immediately; a late `imem_rvalid` after reset release is ignored in IDLE/FETCH.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- When defined: adds output `if_misalign` (1 bit, reset 0).
  - A redirect with `branch_target[1:0]`≠0 sets `if_misalign`=1 next cycle; it is sticky until reset.
  - The pc is still written, but FETCH issues no further requests while `if_misalign`=1.
- When undefined: no port is added; low bits are passed through unchecked and fetch continues.

Test Plan:
- Reset release, `pc`=0x1000, `gnt` immediate, `rvalid` 1 cycle later with 0xD503201F → `pc_write` pulse with `newpc`=0x1004; `if_valid`=1 with `if_pc`=0x1000 and `if_instr`=0xD503201F.
- `id_ready`=0 for 5 cycles over 3 responses → queue holds 2 entries, no third `imem_req`; outputs stable. On `id_ready`=1, entries drain in order 0x1000, 0x1004, then fetch of 0x1008 resumes.
- `branch_taken` with target 0x2000 while in WAIT; `rvalid` arrives 2 cycles later → that response is dropped, `if_valid` stays 0, `newpc`=0x2000, and the next request has `imem_addr`=0x2000.
- `branch_taken` in the same cycle as `imem_rvalid` → no push; `pc_write`/`newpc`=target; state returns to FETCH.
- `pc`=0xFFFF_FFFF_FFFF_FFFC granted → `newpc`=0.
- Reset asserted (0) mid-WAIT → all outputs 0 asynchronously; a subsequent `rvalid` produces no `if_valid`.
- With IF_ALIGN_CHECK_EN, redirect to 0x2002 → `if_misalign`=1 and `imem_req` stays 0.
